// File: rtl/bcd_to_ex3_serial_pkg.sv
// Shared definitions for the bit-serial BCD-to-Excess-3 encoder.
//   ex3_state_t : serial-adder states, with the running carry folded into the state
//   EX3_OFFSET  : constant added to every digit
//   BCD_MAX     : largest legal BCD digit
package bcd_pkg;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1_C0 = 3'd1,
    S1_C1 = 3'd2,
    S2_C0 = 3'd3,
    S2_C1 = 3'd4,
    S3_C0 = 3'd5,
    S3_C1 = 3'd6
  } ex3_state_t;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_to_ex3_serial_if.sv
// Serial stream bundle for the BCD-to-Excess-3 encoder.
//   in_valid / in_bit                         : BCD bit stream, LSB first
//   out_valid / out_bit / out_last / digit_err : Excess-3 bit stream, LSB first
// master = stream producer / result consumer, slave = encoder.
interface bcd_to_ex3_serial_if;

  logic in_valid;
  logic in_bit;
  logic out_valid;
  logic out_bit;
  logic out_last;
  logic digit_err;

  modport master (
    output in_valid,
    output in_bit,
    input  out_valid,
    input  out_bit,
    input  out_last,
    input  digit_err
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    output out_valid,
    output out_bit,
    output out_last,
    output digit_err
  );

endinterface

// File: rtl/bcd_to_ex3_serial.sv
// Bit-serial BCD-to-Excess-3 encoder: adds 0011 to each 4-bit digit arriving
// LSB first, one output bit per accepted input bit, one cycle of latency.
// Digits above 9 are still encoded ((d+3) mod 16) and flagged on their MSB.
// Ports:
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   clr         : digit-alignment restart (drops partial digit, keeps digit_count)
//   bus         : serial stream interface (slave side)
//   digit_count : completed digits, modulo 2^CNT_W
module bcd_to_ex3_serial
  import bcd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  bcd_to_ex3_serial_if.slave bus,
  output logic [CNT_W-1:0] digit_count
);

  ex3_state_t       state_r;
  ex3_state_t       state_nxt_s;
  logic             hi_seen_r;
  logic             hi_seen_nxt_s;
  logic             accept_s;
  logic             sum_s;
  logic             last_s;
  logic             err_s;
  logic             b_s;

  logic             out_valid_r;
  logic             out_bit_r;
  logic             out_last_r;
  logic             digit_err_r;
  logic [CNT_W-1:0] cnt_r;

  assign b_s      = bus.in_bit;
  assign accept_s = bus.in_valid & ~clr;

  // Next-state, sum bit, digit-end marker and error flag of the serial adder.
  always_comb begin
    state_nxt_s   = state_r;
    hi_seen_nxt_s = hi_seen_r;
    sum_s         = 1'b0;
    last_s        = 1'b0;
    err_s         = 1'b0;
    if (clr) begin
      state_nxt_s   = S0;
      hi_seen_nxt_s = 1'b0;
    end else if (bus.in_valid) begin
      case (state_r)
        // bit 0 of the offset is 1, no carry in
        S0: begin
          sum_s         = ~b_s;
          state_nxt_s   = b_s ? S1_C1 : S1_C0;
          hi_seen_nxt_s = 1'b0;
        end
        // bit 1 of the offset is 1: sum = b ^ ~c, carry = b | c
        S1_C0: begin
          sum_s         = ~b_s;
          state_nxt_s   = b_s ? S2_C1 : S2_C0;
          hi_seen_nxt_s = hi_seen_r | b_s;
        end
        S1_C1: begin
          sum_s         = b_s;
          state_nxt_s   = S2_C1;
          hi_seen_nxt_s = hi_seen_r | b_s;
        end
        // bit 2 of the offset is 0: sum = b ^ c, carry = b & c
        S2_C0: begin
          sum_s         = b_s;
          state_nxt_s   = S3_C0;
          hi_seen_nxt_s = hi_seen_r | b_s;
        end
        S2_C1: begin
          sum_s         = ~b_s;
          state_nxt_s   = b_s ? S3_C1 : S3_C0;
          hi_seen_nxt_s = hi_seen_r | b_s;
        end
        // MSB: final carry is dropped; digit > 9 means bit3 with bit1 or bit2
        S3_C0: begin
          sum_s         = b_s;
          last_s        = 1'b1;
          err_s         = b_s & hi_seen_r;
          state_nxt_s   = S0;
          hi_seen_nxt_s = 1'b0;
        end
        S3_C1: begin
          sum_s         = ~b_s;
          last_s        = 1'b1;
          err_s         = b_s & hi_seen_r;
          state_nxt_s   = S0;
          hi_seen_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s   = S0;
          hi_seen_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s   = state_r;
      hi_seen_nxt_s = hi_seen_r;
    end
  end

  // FSM state and sticky high-digit flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S0;
      hi_seen_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hi_seen_r <= hi_seen_nxt_s;
    end
  end

  // Output register stage; data outputs are zeroed whenever not valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_bit_r   <= 1'b0;
      out_last_r  <= 1'b0;
      digit_err_r <= 1'b0;
    end else begin
      out_valid_r <= accept_s;
      out_bit_r   <= accept_s & sum_s;
      out_last_r  <= accept_s & last_s;
      digit_err_r <= accept_s & err_s;
    end
  end

  // Completed-digit counter; clr leaves it untouched, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s && last_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_bit   = out_bit_r;
  assign bus.out_last  = out_last_r;
  assign bus.digit_err = digit_err_r;
  assign digit_count   = cnt_r;

endmodule

// File: tb/tb_bcd_to_ex3_serial.sv
// Self-checking bench for bcd_to_ex3_serial (CNT_W = 4 so the counter wrap is
// reachable). Expected output bits are pushed when stimulus is driven and
// popped by a monitor that samples 1 time unit after each rising edge.
module tb_bcd_to_ex3_serial;
  import bcd_pkg::*;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic b;
    logic last;
    logic err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [CNT_W-1:0] digit_count;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_v;
  exp_t             sb_q[$];
  int               vectors;
  int               errs;

  bcd_to_ex3_serial_if bus ();

  bcd_to_ex3_serial #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .bus         (bus),
    .digit_count (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one cycle of stimulus, applied on the falling edge
  task automatic drive(input logic v, input logic b, input logic c, input logic r);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bit   = b;
    clr          = c;
    rst_n        = r;
    if (!r) exp_cnt = '0;
  endtask

  // send the first n bits of digit d and push their expected Excess-3 bits
  task automatic send_digit(input logic [3:0] d, input int n);
    logic [3:0] e;
    exp_t       x;
    e = d + 4'd3;
    for (int i = 0; i < n; i++) begin
      x.b    = e[i];
      x.last = (i == 3);
      x.err  = (i == 3) && (d > BCD_MAX);
      drive(1'b1, d[i], 1'b0, 1'b1);
      sb_q.push_back(x);
      if (i == 3) exp_cnt = exp_cnt + 4'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compares every cycle against the scoreboard or the idle state.
  always @(posedge clk) begin
    exp_t e;
    exp_v = bus.in_valid && !clr && rst_n;
    #1;
    check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
    if (exp_v) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("out_bit",   {31'd0, bus.out_bit},   {31'd0, e.b});
        check_val("out_last",  {31'd0, bus.out_last},  {31'd0, e.last});
        check_val("digit_err", {31'd0, bus.digit_err}, {31'd0, e.err});
      end
    end else begin
      check_val("idle_bit",  {31'd0, bus.out_bit},   32'd0);
      check_val("idle_last", {31'd0, bus.out_last},  32'd0);
      check_val("idle_err",  {31'd0, bus.digit_err}, 32'd0);
    end
    check_val("digit_count", {28'd0, digit_count}, {28'd0, exp_cnt});
  end

  initial begin
    vectors      = 0;
    errs         = 0;
    exp_cnt      = '0;
    rst_n        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // digit 0
    send_digit(4'd0, 4);
    idle(1);
    check_val("cnt_after_0", {28'd0, digit_count}, 32'd1);

    // 5, 9, 2 back-to-back
    send_digit(4'd5, 4);
    send_digit(4'd9, 4);
    send_digit(4'd2, 4);
    idle(1);
    check_val("cnt_after_592", {28'd0, digit_count}, 32'd4);

    // invalid digits
    send_digit(4'd10, 4);
    send_digit(4'd15, 4);
    send_digit(4'd12, 4);
    idle(1);

    // digit 7 with a 3-cycle gap after bit 1
    begin
      logic [3:0] d;
      exp_t x;
      d = 4'd7;
      for (int i = 0; i < 4; i++) begin
        x.b = 1'(4'd10 >> i);
        x.last = (i == 3);
        x.err = 1'b0;
        drive(1'b1, d[i], 1'b0, 1'b1);
        sb_q.push_back(x);
        if (i == 3) exp_cnt = exp_cnt + 4'd1;
        if (i == 1) idle(3);
      end
    end
    idle(1);

    // clr after 2 bits (with in_valid high, bit discarded), then digit 4
    send_digit(4'd13, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    send_digit(4'd4, 4);
    idle(1);
    check_val("cnt_after_clr", {28'd0, digit_count}, 32'd9);

    // reset after 2 bits of digit 6, then digit 8
    send_digit(4'd6, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    send_digit(4'd8, 4);
    idle(1);
    check_val("cnt_after_rst", {28'd0, digit_count}, 32'd1);

    // exhaustive sweep from reset, 17 digits wraps the 4-bit counter to 1
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int k = 0; k < 17; k++) send_digit(4'(k), 4);
    idle(2);
    check_val("cnt_wrap", {28'd0, digit_count}, 32'd1);
    check_val("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
